// File: rtl/dec_block_lock_ctrl_if.sv
// Handshake bundle between link training and the block-lock controller.
// The master drives the symbol headers and controls; the slave (the controller) returns lock status.
interface dec_block_lock_ctrl_if;
  logic       link_en;
  logic [1:0] gen_speed;
  logic       sym_valid;
  logic [3:0] lane_0_hdr;
  logic [3:0] lane_1_hdr;
  logic       enable_dec;
  logic       block_lock;
  logic       slip_0;
  logic       slip_1;
  logic       lock_lost;
  logic [1:0] state;
  logic [7:0] relock_count;

  modport master (
    output link_en, gen_speed, sym_valid, lane_0_hdr, lane_1_hdr,
    input  enable_dec, block_lock, slip_0, slip_1, lock_lost, state, relock_count
  );

  modport slave (
    input  link_en, gen_speed, sym_valid, lane_0_hdr, lane_1_hdr,
    output enable_dec, block_lock, slip_0, slip_1, lock_lost, state, relock_count
  );
endinterface

// File: rtl/dec_block_lock_ctrl.sv
// Two-lane sync-header block-lock controller for Gen2/Gen3/Gen4 decoding.
// Optional macro LOCK_STATS_EN enables the saturating relock_count statistic.
module dec_block_lock_ctrl #(
  parameter int LOCK_CNT  = 64,
  parameter int WINDOW    = 1024,
  parameter int BAD_LIMIT = 16,
  parameter int SLIP_WAIT = 4
) (
  input  logic                  enc_clk,
  input  logic                  rst,
  dec_block_lock_ctrl_if.slave  bus_if
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(WINDOW);
  localparam int BAD_W  = $clog2(BAD_LIMIT + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_HUNT      = 2'b01,
    ST_SLIP_WAIT = 2'b10,
    ST_LOCKED    = 2'b11
  } state_t;

  state_t              state_q;
  logic [GOOD_W-1:0]   good_cnt_q;
  logic [WIN_W-1:0]    win_cnt_q;
  logic [BAD_W-1:0]    bad_cnt_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [1:0]          gen_prev_q;
  logic                enable_dec_q;
  logic                block_lock_q;
  logic                slip_0_q;
  logic                slip_1_q;
  logic                lock_lost_q;

  logic                lane0_ok;
  logic                lane1_ok;
  logic                sym_good;
  logic                slip_allowed;
  logic                gen_changed;
  logic [BAD_W-1:0]    bad_cnt_d;
  logic                win_last;
  logic                lose_lock;

  always_comb begin
    lane0_ok     = 1'b0;
    lane1_ok     = 1'b0;
    slip_allowed = 1'b0;
    case (bus_if.gen_speed)
      2'b10: begin
        lane0_ok     = (bus_if.lane_0_hdr[1:0] == 2'b01) || (bus_if.lane_0_hdr[1:0] == 2'b10);
        lane1_ok     = (bus_if.lane_1_hdr[1:0] == 2'b01) || (bus_if.lane_1_hdr[1:0] == 2'b10);
        slip_allowed = 1'b1;
      end
      2'b01: begin
        lane0_ok     = (bus_if.lane_0_hdr == 4'b0101) || (bus_if.lane_0_hdr == 4'b1010);
        lane1_ok     = (bus_if.lane_1_hdr == 4'b0101) || (bus_if.lane_1_hdr == 4'b1010);
        slip_allowed = 1'b1;
      end
      2'b00: begin
        lane0_ok = 1'b1;
        lane1_ok = 1'b1;
      end
      default: begin
        lane0_ok = 1'b0;
        lane1_ok = 1'b0;
      end
    endcase
    sym_good    = lane0_ok && lane1_ok;
    gen_changed = (bus_if.gen_speed != gen_prev_q);
    win_last    = (win_cnt_q == WIN_W'(WINDOW - 1));
    bad_cnt_d   = bad_cnt_q;
    if (!sym_good && (bad_cnt_q != BAD_W'(BAD_LIMIT))) begin
      bad_cnt_d = bad_cnt_q + 1'b1;
    end
    // Every way out of LOCKED; shared by the FSM and the relock statistic.
    lose_lock = (state_q == ST_LOCKED) &&
                (!bus_if.link_en || gen_changed ||
                 (bus_if.sym_valid && (bad_cnt_d == BAD_W'(BAD_LIMIT))));
  end

  always_ff @(posedge enc_clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      good_cnt_q   <= '0;
      win_cnt_q    <= '0;
      bad_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      gen_prev_q   <= 2'b00;
      enable_dec_q <= 1'b0;
      block_lock_q <= 1'b0;
      slip_0_q     <= 1'b0;
      slip_1_q     <= 1'b0;
      lock_lost_q  <= 1'b0;
    end else begin
      gen_prev_q  <= bus_if.gen_speed;
      slip_0_q    <= 1'b0;
      slip_1_q    <= 1'b0;
      lock_lost_q <= lose_lock;

      if (!bus_if.link_en) begin
        state_q      <= ST_IDLE;
        good_cnt_q   <= '0;
        win_cnt_q    <= '0;
        bad_cnt_q    <= '0;
        wait_cnt_q   <= '0;
        enable_dec_q <= 1'b0;
        block_lock_q <= 1'b0;
      end else if ((state_q != ST_IDLE) && gen_changed) begin
        state_q      <= ST_HUNT;
        good_cnt_q   <= '0;
        win_cnt_q    <= '0;
        bad_cnt_q    <= '0;
        wait_cnt_q   <= '0;
        enable_dec_q <= 1'b0;
        block_lock_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            good_cnt_q <= '0;
            win_cnt_q  <= '0;
            bad_cnt_q  <= '0;
            wait_cnt_q <= '0;
            state_q    <= ST_HUNT;
          end

          ST_HUNT: begin
            if (bus_if.sym_valid) begin
              if (sym_good) begin
                if (good_cnt_q >= GOOD_W'(LOCK_CNT - 1)) begin
                  good_cnt_q   <= GOOD_W'(LOCK_CNT);
                  win_cnt_q    <= '0;
                  bad_cnt_q    <= '0;
                  state_q      <= ST_LOCKED;
                  enable_dec_q <= 1'b1;
                  block_lock_q <= 1'b1;
                end else begin
                  good_cnt_q <= good_cnt_q + 1'b1;
                end
              end else begin
                good_cnt_q <= '0;
                wait_cnt_q <= '0;
                slip_0_q   <= slip_allowed && !lane0_ok;
                slip_1_q   <= slip_allowed && !lane1_ok;
                state_q    <= ST_SLIP_WAIT;
              end
            end
          end

          // The aligner needs a few cycles to apply the slip, so headers are ignored here.
          ST_SLIP_WAIT: begin
            if (wait_cnt_q >= WAIT_W'(SLIP_WAIT - 1)) begin
              wait_cnt_q <= '0;
              good_cnt_q <= '0;
              state_q    <= ST_HUNT;
            end else begin
              wait_cnt_q <= wait_cnt_q + 1'b1;
            end
          end

          ST_LOCKED: begin
            if (bus_if.sym_valid) begin
              if (bad_cnt_d == BAD_W'(BAD_LIMIT)) begin
                state_q      <= ST_HUNT;
                good_cnt_q   <= '0;
                win_cnt_q    <= '0;
                bad_cnt_q    <= '0;
                enable_dec_q <= 1'b0;
                block_lock_q <= 1'b0;
              end else if (win_last) begin
                win_cnt_q <= '0;
                bad_cnt_q <= '0;
              end else begin
                win_cnt_q <= win_cnt_q + 1'b1;
                bad_cnt_q <= bad_cnt_d;
              end
            end
          end

          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef LOCK_STATS_EN
  logic [7:0] relock_q;

  always_ff @(posedge enc_clk or posedge rst) begin
    if (rst) begin
      relock_q <= 8'd0;
    end else if (lose_lock && (relock_q != 8'hFF)) begin
      relock_q <= relock_q + 8'd1;
    end
  end

  assign bus_if.relock_count = relock_q;
`else
  assign bus_if.relock_count = 8'd0;
`endif

  assign bus_if.enable_dec = enable_dec_q;
  assign bus_if.block_lock = block_lock_q;
  assign bus_if.slip_0     = slip_0_q;
  assign bus_if.slip_1     = slip_1_q;
  assign bus_if.lock_lost  = lock_lost_q;
  assign bus_if.state      = state_q;

endmodule

// File: tb/tb_dec_block_lock_ctrl.sv
// Directed bench for dec_block_lock_ctrl: lock, slip, window loss, gen changes, link drop, reset.
// Expected relock_count follows LOCK_STATS_EN when the bench is built with that macro.
module tb_dec_block_lock_ctrl;

  logic enc_clk = 1'b0;
  logic rst;

  dec_block_lock_ctrl_if bus ();

  dec_block_lock_ctrl dut (
    .enc_clk (enc_clk),
    .rst     (rst),
    .bus_if  (bus)
  );

  always #5 enc_clk = ~enc_clk;

  int checks       = 0;
  int failures     = 0;
  int slipSeen     = 0;
  int lockLostSeen = 0;
  int slipInLocked = 0;
  int expRelock    = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One enc_clk cycle of stimulus; outputs are sampled 1 ns after the edge.
  task automatic applyStimulus(input logic v, input logic [3:0] h0, input logic [3:0] h1);
    bus.sym_valid  = v;
    bus.lane_0_hdr = h0;
    bus.lane_1_hdr = h1;
    @(posedge enc_clk);
    #1;
    if (bus.slip_0 || bus.slip_1) slipSeen++;
    if ((bus.slip_0 || bus.slip_1) && (bus.state == 2'b11)) slipInLocked++;
    if (bus.lock_lost) lockLostSeen++;
    bus.sym_valid = 1'b0;
  endtask

  function automatic logic [3:0] goodHdr(input logic [1:0] gen, input int i);
    logic [3:0] h;
    case (gen)
      2'b10:   h = (i % 2 == 0) ? 4'b1101 : 4'b0010;
      2'b01:   h = (i % 2 == 0) ? 4'b0101 : 4'b1010;
      default: h = 4'($urandom_range(0, 15));
    endcase
    return h;
  endfunction

  task automatic sendGood(input int n, input logic [1:0] gen);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, goodHdr(gen, i), goodHdr(gen, i + 1));
    end
  endtask

  function automatic logic [7:0] relockExp();
`ifdef LOCK_STATS_EN
    return 8'(expRelock);
`else
    return 8'd0;
`endif
  endfunction

  initial begin
    rst            = 1'b1;
    bus.link_en    = 1'b0;
    bus.gen_speed  = 2'b00;
    bus.sym_valid  = 1'b0;
    bus.lane_0_hdr = 4'b0000;
    bus.lane_1_hdr = 4'b0000;
    repeat (2) @(posedge enc_clk);
    #1;
    checkOutput("rst_state", 32'(bus.state), 32'd0);
    checkOutput("rst_enable", 32'(bus.enable_dec), 32'd0);
    checkOutput("rst_lock", 32'(bus.block_lock), 32'd0);
    checkOutput("rst_slips", 32'({bus.slip_0, bus.slip_1}), 32'd0);
    checkOutput("rst_relock", 32'(bus.relock_count), 32'd0);
    rst = 1'b0;

    // Gen2 lock after exactly LOCK_CNT good symbols.
    bus.gen_speed = 2'b10;
    bus.link_en   = 1'b1;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput("g2_hunt", 32'(bus.state), 32'd1);
    sendGood(63, 2'b10);
    checkOutput("g2_63_enable", 32'(bus.enable_dec), 32'd0);
    sendGood(1, 2'b10);
    checkOutput("g2_64_enable", 32'(bus.enable_dec), 32'd1);
    checkOutput("g2_64_lock", 32'(bus.block_lock), 32'd1);
    checkOutput("g2_64_state", 32'(bus.state), 32'd3);
    checkOutput("g2_noslip", 32'(slipSeen), 32'd0);

    // 16 bad symbols in one window lose lock without a slip.
    lockLostSeen = 0;
    repeat (15) applyStimulus(1'b1, 4'b0000, 4'b0110);
    checkOutput("bad15_lock", 32'(bus.block_lock), 32'd1);
    checkOutput("bad15_nolost", 32'(lockLostSeen), 32'd0);
    applyStimulus(1'b1, 4'b0000, 4'b0110);
    expRelock++;
    checkOutput("bad16_lost", 32'(bus.lock_lost), 32'd1);
    checkOutput("bad16_enable", 32'(bus.enable_dec), 32'd0);
    checkOutput("bad16_state", 32'(bus.state), 32'd1);
    checkOutput("bad16_slip", 32'(bus.slip_0), 32'd0);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput("lost_pulse_end", 32'(bus.lock_lost), 32'd0);

    // 15 bad per window at window ends: windows must restart, lock held.
    sendGood(64, 2'b10);
    checkOutput("relock_g2", 32'(bus.block_lock), 32'd1);
    lockLostSeen = 0;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 1024; i++) begin
        if (i >= 1009) applyStimulus(1'b1, 4'b0001, 4'b0011);
        else           applyStimulus(1'b1, goodHdr(2'b10, i), goodHdr(2'b10, i + 1));
      end
    end
    checkOutput("win3_lock", 32'(bus.block_lock), 32'd1);
    checkOutput("win3_nolost", 32'(lockLostSeen), 32'd0);

    // 16th bad on the last symbol of a window: loss wins.
    sendGood(1008, 2'b10);
    repeat (15) applyStimulus(1'b1, 4'b0001, 4'b0011);
    checkOutput("edge15_lock", 32'(bus.block_lock), 32'd1);
    applyStimulus(1'b1, 4'b0001, 4'b0011);
    expRelock++;
    checkOutput("edge16_lost", 32'(bus.lock_lost), 32'd1);
    checkOutput("edge16_state", 32'(bus.state), 32'd1);

    // Gen3: lane 1 bad on symbol 10 slips lane 1 only, then waits 4 cycles.
    bus.gen_speed = 2'b01;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput("g3_hunt", 32'(bus.state), 32'd1);
    sendGood(9, 2'b01);
    applyStimulus(1'b1, 4'b0101, 4'b0000);
    checkOutput("g3_slip1", 32'(bus.slip_1), 32'd1);
    checkOutput("g3_slip0", 32'(bus.slip_0), 32'd0);
    checkOutput("g3_wait0", 32'(bus.state), 32'd2);
    slipSeen = 0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 4'b0101, 4'b1010);
      checkOutput($sformatf("g3_wait%0d", k), 32'(bus.state), (k < 4) ? 32'd2 : 32'd1);
    end
    checkOutput("g3_single_slip", 32'(slipSeen), 32'd0);
    sendGood(63, 2'b01);
    checkOutput("g3_63_enable", 32'(bus.enable_dec), 32'd0);
    sendGood(1, 2'b01);
    checkOutput("g3_64_lock", 32'(bus.block_lock), 32'd1);

    // Gen change out of LOCKED, then Gen4 locks on any headers.
    bus.gen_speed = 2'b00;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    expRelock++;
    checkOutput("gchg_lost", 32'(bus.lock_lost), 32'd1);
    checkOutput("gchg_state", 32'(bus.state), 32'd1);
    checkOutput("gchg_enable", 32'(bus.enable_dec), 32'd0);
    slipSeen = 0;
    sendGood(63, 2'b00);
    checkOutput("g4_63_state", 32'(bus.state), 32'd1);
    sendGood(1, 2'b00);
    checkOutput("g4_64_lock", 32'(bus.block_lock), 32'd1);
    lockLostSeen = 0;
    sendGood(200, 2'b00);
    checkOutput("g4_hold", 32'(bus.block_lock), 32'd1);
    checkOutput("g4_nolost", 32'(lockLostSeen), 32'd0);
    checkOutput("g4_noslip", 32'(slipSeen), 32'd0);
    bus.gen_speed = 2'b01;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    expRelock++;
    checkOutput("g4to3_lost", 32'(bus.lock_lost), 32'd1);
    checkOutput("g4to3_state", 32'(bus.state), 32'd1);

    // gen_speed=11: every symbol bad, slips suppressed, never locks.
    bus.gen_speed = 2'b11;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    slipSeen = 0;
    applyStimulus(1'b1, 4'b0101, 4'b0101);
    checkOutput("g11_wait", 32'(bus.state), 32'd2);
    checkOutput("g11_slips", 32'({bus.slip_0, bus.slip_1}), 32'd0);
    repeat (70) applyStimulus(1'b1, 4'b0101, 4'b1010);
    checkOutput("g11_nolock", 32'(bus.block_lock), 32'd0);
    checkOutput("g11_noslip", 32'(slipSeen), 32'd0);

    // link_en drop from LOCKED.
    bus.gen_speed = 2'b10;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput("g2b_hunt", 32'(bus.state), 32'd1);
    sendGood(64, 2'b10);
    checkOutput("g2b_lock", 32'(bus.block_lock), 32'd1);
    bus.link_en = 1'b0;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    expRelock++;
    checkOutput("linkoff_state", 32'(bus.state), 32'd0);
    checkOutput("linkoff_enable", 32'(bus.enable_dec), 32'd0);
    checkOutput("linkoff_lost", 32'(bus.lock_lost), 32'd1);
    checkOutput("relock_count", 32'(bus.relock_count), 32'(relockExp()));
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkOutput("idle_hold", 32'(bus.state), 32'd0);
    checkOutput("idle_lost_end", 32'(bus.lock_lost), 32'd0);

    // Async reset lands during SLIP_WAIT with a slip pulse visible.
    bus.link_en = 1'b1;
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    applyStimulus(1'b1, 4'b0000, 4'b0001);
    checkOutput("pre_rst_slip0", 32'(bus.slip_0), 32'd1);
    checkOutput("pre_rst_slip1", 32'(bus.slip_1), 32'd0);
    checkOutput("pre_rst_state", 32'(bus.state), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_state", 32'(bus.state), 32'd0);
    checkOutput("arst_slip0", 32'(bus.slip_0), 32'd0);
    checkOutput("arst_enable", 32'(bus.enable_dec), 32'd0);
    checkOutput("arst_lock", 32'(bus.block_lock), 32'd0);
    checkOutput("arst_relock", 32'(bus.relock_count), 32'd0);
    @(posedge enc_clk);
    #1;
    rst = 1'b0;

    checkOutput("slip_in_locked", 32'(slipInLocked), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
